// File: rtl/add_pkg.sv
// -----------------------------------------------------------------------------
// add_pkg
// Shared types and helpers for the adder result stage.
//   ADD_WIDTH    : operand/sum width of the team's ripple-carry adder.
//   res_entry_t  : one registered result (sum plus derived status flags).
//   skid_state_t : occupancy of the 2-entry output skid buffer.
//   calc_ovf     : signed overflow from the two most significant carries.
// -----------------------------------------------------------------------------
package add_pkg;

    localparam int ADD_WIDTH = 4;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
        logic                 zero;
        logic                 neg;
    } res_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Signed overflow occurs when the carry into the sign bit differs from
    // the carry out of it.
    function automatic logic calc_ovf(input logic carry_msb, input logic carry_prev);
        return carry_msb ^ carry_prev;
    endfunction

endpackage

// File: rtl/add_result_stage_if.sv
// -----------------------------------------------------------------------------
// add_result_stage_if
// Valid/ready handshake bundle around the adder result stage.
//   Upstream side  : in_valid, in_ready, in_s (sum bits), in_c (per-bit carries)
//   Downstream side: out_valid, out_ready, out_sum, out_cout, out_ovf,
//                    out_zero, out_neg
// Modports:
//   slave  : the result stage itself.
//   master : the environment that feeds the adder result and consumes it.
// -----------------------------------------------------------------------------
interface add_result_stage_if
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport slave (
        input  in_valid, in_s, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport master (
        output in_valid, in_s, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/add_flag_calc.sv
// -----------------------------------------------------------------------------
// add_flag_calc
// Combinational flag derivation for one adder result.
//   in_s : adder sum bits
//   in_c : adder per-stage carries, in_c[WIDTH-1] is the final carry-out
//   res  : packed result entry (sum, cout, ovf, zero, neg)
// Optional build macro ADD_RESULT_SATURATE_EN: clamps the stored sum to the
// most positive / most negative value on signed overflow; zero and neg then
// describe the clamped value while ovf still reports the overflow.
// WIDTH must match add_pkg::ADD_WIDTH because the entry type is shared.
// -----------------------------------------------------------------------------
module add_flag_calc
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_c,
    output res_entry_t       res
);

    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             unused_carries_s;

    // Only the top two carries matter; the lower ones are ripple internals.
    assign unused_carries_s = ^in_c;

    // Build the entry: overflow, optional clamp, then flags from the stored sum.
    always_comb begin
        ovf_s = calc_ovf(in_c[WIDTH-1], in_c[WIDTH-2]);
        sum_s = in_s;
`ifdef ADD_RESULT_SATURATE_EN
        if (ovf_s) begin
            // A sum that wrapped negative came from a positive overflow.
            if (in_s[WIDTH-1]) begin
                sum_s = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                sum_s = {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            sum_s = in_s;
        end
`endif
        res.sum  = sum_s;
        res.cout = in_c[WIDTH-1];
        res.ovf  = ovf_s;
        res.zero = (sum_s == {WIDTH{1'b0}});
        res.neg  = sum_s[WIDTH-1];
    end

endmodule

// File: rtl/add_result_stage.sv
// -----------------------------------------------------------------------------
// add_result_stage
// Registered output stage behind the ripple-carry adder. Each accepted result
// is turned into an entry (sum + flags) and held in a 2-entry skid buffer so
// downstream backpressure never drops or duplicates a result.
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset
//   bus         : add_result_stage_if.slave (in_* upstream, out_* downstream)
//   clear_count : synchronous clear of ovf_count (wins over an increment)
//   ovf_count   : saturating count of accepted results with signed overflow
// Optional build macro ADD_RESULT_SATURATE_EN (see add_flag_calc).
// -----------------------------------------------------------------------------
module add_result_stage
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    add_result_stage_if.slave  bus,
    input  logic               clear_count,
    output logic [CNT_W-1:0]   ovf_count
);

    skid_state_t      state_r;
    res_entry_t       main_r;
    res_entry_t       skid_r;
    res_entry_t       new_entry_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] ovf_count_r;
    logic             accept_s;
    logic             consume_s;

    add_flag_calc #(
        .WIDTH (WIDTH)
    ) u_flag_calc (
        .in_s (bus.in_s),
        .in_c (bus.in_c),
        .res  (new_entry_s)
    );

    assign accept_s  = bus.in_valid & in_ready_r;
    assign consume_s = out_valid_r & bus.out_ready;

    // Skid buffer FSM: main drives the outputs, skid catches one extra
    // result while the consumer stalls; in_ready is registered (!FULL).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            main_r      <= '0;
            skid_r      <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_r      <= new_entry_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ONE;
                    end
                end
                ONE: begin
                    if (accept_s && consume_s) begin
                        main_r <= new_entry_s;
                    end else if (accept_s) begin
                        skid_r     <= new_entry_s;
                        in_ready_r <= 1'b0;
                        state_r    <= FULL;
                    end else if (consume_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume_s) begin
                        main_r     <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= ONE;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating overflow event counter; clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count_r <= '0;
        end else if (clear_count) begin
            ovf_count_r <= '0;
        end else if (accept_s && new_entry_s.ovf && (ovf_count_r != {CNT_W{1'b1}})) begin
            ovf_count_r <= ovf_count_r + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = main_r.sum;
    assign bus.out_cout  = main_r.cout;
    assign bus.out_ovf   = main_r.ovf;
    assign bus.out_zero  = main_r.zero;
    assign bus.out_neg   = main_r.neg;
    assign ovf_count     = ovf_count_r;

endmodule

// File: tb/tb_add_result_stage.sv
// -----------------------------------------------------------------------------
// tb_add_result_stage
// Self-checking bench for add_result_stage. Operands a/b are added by a small
// ripple-carry adder in the bench to produce in_s/in_c; the reference model
// computes each expected entry from plain integer arithmetic on a and b and
// keeps the expected buffer contents in a queue. Honours
// ADD_RESULT_SATURATE_EN when defined.
// -----------------------------------------------------------------------------
module tb_add_result_stage;
    import add_pkg::*;

    localparam int W       = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = 255;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_count;
    logic [CW-1:0] ovf_count;

    add_result_stage_if #(.WIDTH(W)) bus ();

    add_result_stage #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .clear_count (clear_count),
        .ovf_count   (ovf_count)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t last_shown;
    int   cnt_m;

    // Upstream ripple-carry adder: per-bit carry-out vector.
    function automatic logic [W-1:0] carries(input logic [W-1:0] a, input logic [W-1:0] b);
        logic         c;
        logic [W-1:0] cv;
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
            c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            cv[i] = c;
        end
        return cv;
    endfunction

    // Expected entry from integer arithmetic.
    function automatic exp_t exp_of(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   u;
        int   sa;
        int   sb;
        int   sv;
        u  = int'(a) + int'(b);
        sa = a[W-1] ? int'(a) - 16 : int'(a);
        sb = b[W-1] ? int'(b) - 16 : int'(b);
        sv = sa + sb;
        e.sum  = 4'(u);
        e.cout = (u >= 16);
        e.ovf  = (sv > 7) || (sv < -8);
`ifdef ADD_RESULT_SATURATE_EN
        if (sv > 7) e.sum = 4'd7;
        else if (sv < -8) e.sum = 4'd8;
`endif
        e.zero = (e.sum == 4'd0);
        e.neg  = e.sum[W-1];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic check_cycle();
        chk("out_valid", bus.out_valid, q.size() > 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        chk("ovf_count", ovf_count, cnt_m);
        if (q.size() > 0) last_shown = q[0];
        chk("out_sum", bus.out_sum, last_shown.sum);
        chk("out_cout", bus.out_cout, last_shown.cout);
        chk("out_ovf", bus.out_ovf, last_shown.ovf);
        chk("out_zero", bus.out_zero, last_shown.zero);
        chk("out_neg", bus.out_neg, last_shown.neg);
    endtask

    // Drive one cycle, advance the model across the edge, then compare.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, input logic clr, output bit accepted);
        exp_t e;
        bit   cons;
        bus.in_valid  = v;
        bus.in_s      = a + b;
        bus.in_c      = carries(a, b);
        bus.out_ready = ordy;
        clear_count   = clr;
        e        = exp_of(a, b);
        accepted = v && (q.size() < 2);
        cons     = ordy && (q.size() > 0);
        if (cons) void'(q.pop_front());
        if (accepted) q.push_back(e);
        if (clr) cnt_m = 0;
        else if (accepted && e.ovf && cnt_m < CNT_MAX) cnt_m++;
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic model_reset();
        q.delete();
        cnt_m      = 0;
        last_shown = '{default: 0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit           acc;
        bit           pend;
        logic         v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;
        clear_count   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cycle();
        reset = 1'b0;

        // 5 + 0: plain result, one-cycle latency.
        step(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, acc);
        chk("t1_sum", bus.out_sum, 4'd5);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_flags", {bus.out_cout, bus.out_ovf, bus.out_zero, bus.out_neg}, 4'b0000);
        chk("t1_model", q[0].sum, 4'd5);

        // 7 + 1: positive overflow.
        step(1'b1, 4'd7, 4'd1, 1'b1, 1'b0, acc);
        chk("ovf_cnt", ovf_count, 8'd1);
        chk("ovf_ovf", bus.out_ovf, 1'b1);
        chk("ovf_cout", bus.out_cout, 1'b0);
`ifdef ADD_RESULT_SATURATE_EN
        chk("ovf_sum", bus.out_sum, 4'b0111);
        chk("ovf_neg", bus.out_neg, 1'b0);
`else
        chk("ovf_sum", bus.out_sum, 4'b1000);
        chk("ovf_neg", bus.out_neg, 1'b1);
`endif

        // 8 + 8: zero sum with carry-out and overflow.
        step(1'b1, 4'd8, 4'd8, 1'b1, 1'b0, acc);
        chk("zc_cout", bus.out_cout, 1'b1);
        chk("zc_ovf", bus.out_ovf, 1'b1);
        chk("zc_cnt", ovf_count, 8'd2);
`ifdef ADD_RESULT_SATURATE_EN
        chk("zc_sum", bus.out_sum, 4'b1000);
        chk("zc_zero", bus.out_zero, 1'b0);
`else
        chk("zc_sum", bus.out_sum, 4'b0000);
        chk("zc_zero", bus.out_zero, 1'b1);
`endif
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);

        // Backpressure: 1, 2, 3 with the consumer stalled.
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, acc);
        step(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, acc);
        chk("bp_ready_low", bus.in_ready, 1'b0);
        chk("bp_head1", bus.out_sum, 4'd1);
        step(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, acc);
        chk("bp_held3", acc, 1'b0);
        chk("bp_hold1", bus.out_sum, 4'd1);
        step(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, acc);
        chk("bp_head2", bus.out_sum, 4'd2);
        chk("bp_ready_up", bus.in_ready, 1'b1);
        step(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, acc);
        chk("bp_acc3", acc, 1'b1);
        chk("bp_head3", bus.out_sum, 4'd3);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("bp_drained", bus.out_valid, 1'b0);

        // Counter saturation, then clear racing an overflow accept.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 4'd7, 4'd1, 1'b1, 1'b0, acc);
        end
        chk("cnt_sat", ovf_count, 8'd255);
        step(1'b1, 4'd7, 4'd1, 1'b1, 1'b1, acc);
        chk("cnt_clear_wins", ovf_count, 8'd0);
        step(1'b1, 4'd7, 4'd1, 1'b1, 1'b0, acc);
        chk("cnt_after_clear", ovf_count, 8'd1);

        // Randomized traffic; an unaccepted input is held until taken.
        pend = 1'b0;
        v    = 1'b0;
        ra   = '0;
        rb   = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend) begin
                v  = ($urandom_range(0, 3) != 0);
                ra = 4'($urandom);
                rb = 4'($urandom);
            end
            step(v, ra, rb, ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0), acc);
            pend = v && !acc;
        end

        // Asynchronous reset while FULL.
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, acc);
        step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, acc);
        chk("rst_full", bus.in_ready, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_cnt", ovf_count, 8'd0);
        chk("rst_sum", bus.out_sum, 4'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_cycle();
        reset = 1'b0;
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("rst_no_stale", bus.out_valid, 1'b0);
        step(1'b1, 4'd2, 4'd2, 1'b1, 1'b0, acc);
        chk("rst_first", bus.out_sum, 4'd4);
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
